// File: rtl/mean_pkg.sv
// Shared widths, per-channel state record and a constant clog2 for the
// moving-average filter.
package mean_pkg;

   function automatic int clog2(input int value);
      int r = 0;
      int v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int DATA_W   = 8;
   localparam int MAX_LOG2 = 4;
   localparam int CHANNELS = 4;
   localparam int SUM_W    = DATA_W + MAX_LOG2;
   localparam int DEPTH    = 2 ** MAX_LOG2;
   localparam int CH_W     = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS);
   localparam int K_W      = clog2(MAX_LOG2 + 1);

   typedef struct packed {
      logic [SUM_W-1:0]    sum;
      logic [MAX_LOG2:0]   fill;
      logic [MAX_LOG2-1:0] ptr;
   } chan_state_t;

endpackage

// File: rtl/mean_sample_ram.sv
// Sample history for all channels: one synchronous write port and one
// asynchronous read port; a read of the address being written sees old data.
module mean_sample_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int WORDS  = 64
)(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [WORDS];

   // NOTE: storage has no reset; stale words are masked by the fill count instead.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mean_mc.sv
// Multi-channel moving-average filter: per channel, rounded mean of the last
// 2**k samples, one sample per cycle with a one-cycle result latency.
module mean_mc
   import mean_pkg::chan_state_t;
   import mean_pkg::clog2;
#(
   parameter int DATA_W   = mean_pkg::DATA_W,
   parameter int MAX_LOG2 = mean_pkg::MAX_LOG2,
   parameter int CHANNELS = mean_pkg::CHANNELS,
   parameter bit ROUND    = 1'b1,
   localparam int CH_W    = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS),
   localparam int K_W     = clog2(MAX_LOG2 + 1)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [K_W-1:0]    win_log2,
   input  logic              in_valid,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic [DATA_W-1:0] out_data,
   output logic              out_full,
   output logic [K_W-1:0]    k_active
);

   localparam int SUM_W  = DATA_W + MAX_LOG2;
   localparam int DEPTH  = 2 ** MAX_LOG2;
   localparam int FILL_W = MAX_LOG2 + 1;
   localparam int ADDR_W = CH_W + MAX_LOG2;
   localparam logic [K_W-1:0] K_MAX = K_W'(MAX_LOG2);

   chan_state_t         st [CHANNELS];
   chan_state_t         cur;
   logic [K_W-1:0]      k_q;
   logic [K_W-1:0]      k_req;
   logic                ch_ok;
   logic                accept;
   logic [CH_W-1:0]     sel_ch;
   logic [FILL_W-1:0]   win;
   logic [MAX_LOG2-1:0] ptr_mask;
   logic [FILL_W-1:0]   nxt_fill;
   logic [MAX_LOG2-1:0] nxt_ptr;
   logic                nxt_full;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   oldest;
   logic [SUM_W-1:0]    nsum;
   logic [SUM_W:0]      rsum;
   logic [SUM_W:0]      shifted;
   logic [DATA_W-1:0]   mean;

   generate
      if (CHANNELS == (1 << CH_W)) begin : g_ch_pow2
         assign ch_ok = 1'b1;
      end else begin : g_ch_range
         assign ch_ok = (int'(in_ch) < CHANNELS);
      end
   endgenerate

   assign k_req    = (win_log2 > K_MAX) ? K_MAX : win_log2;
   assign k_active = k_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      sel_ch   = ch_ok ? in_ch : '0;
      accept   = in_valid & ~clr & ch_ok;
      cur      = st[sel_ch];
      win      = FILL_W'(1) << k_q;
      ptr_mask = MAX_LOG2'(win - 1'b1);

      // Slots not yet written since the last flush contribute zero.
      oldest   = (cur.fill == win) ? rd_data : '0;
      nsum     = cur.sum - SUM_W'(oldest) + SUM_W'(in_data);

      rsum = {1'b0, nsum};
      if (ROUND && (k_q != '0))
         rsum = rsum + ((SUM_W+1)'(1) << (k_q - 1'b1));
      shifted = rsum >> k_q;
      mean    = (shifted > (SUM_W+1)'(2 ** DATA_W - 1)) ? '1 : shifted[DATA_W-1:0];

      nxt_fill = (cur.fill == win) ? win : cur.fill + 1'b1;
      nxt_ptr  = (cur.ptr + 1'b1) & ptr_mask;
      nxt_full = ((cur.fill + 1'b1) >= win);
   end

   mean_sample_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .WORDS  (CHANNELS * DEPTH)
   ) u_ram (
      .clk     (clk),
      .we      (accept),
      .wr_addr ({sel_ch, cur.ptr}),
      .wr_data (in_data),
      .rd_addr ({sel_ch, cur.ptr}),
      .rd_data (rd_data)
   );

   // NOTE: state and output registers use non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) st[c] <= '0;
         k_q       <= K_MAX;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_full  <= 1'b0;
      end else if (clr) begin
         for (int c = 0; c < CHANNELS; c++) st[c] <= '0;
         k_q       <= k_req;
         out_valid <= 1'b0;
      end else begin
         out_valid <= accept;
         if (accept) begin
            st[sel_ch] <= '{sum: nsum, fill: nxt_fill, ptr: nxt_ptr};
            out_ch     <= sel_ch;
            out_data   <= mean;
            out_full   <= nxt_full;
         end
      end
   end

endmodule

// File: tb/tb_mean_mc.sv
// Bench for mean_mc: queue-based reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_mean_mc;

   localparam int DATA_W   = 8;
   localparam int MAX_LOG2 = 4;
   localparam int CHANNELS = 3;
   localparam int CH_W     = 2;
   localparam int K_W      = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              clr = 1'b0;
   logic [K_W-1:0]    win_log2 = '0;
   logic              in_valid = 1'b0;
   logic [CH_W-1:0]   in_ch = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic [CH_W-1:0]   out_ch;
   logic [DATA_W-1:0] out_data;
   logic              out_full;
   logic [K_W-1:0]    k_active;

   int checks   = 0;
   int failures = 0;

   mean_mc #(
      .DATA_W   (DATA_W),
      .MAX_LOG2 (MAX_LOG2),
      .CHANNELS (CHANNELS),
      .ROUND    (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .win_log2  (win_log2),
      .in_valid  (in_valid),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_full  (out_full),
      .k_active  (k_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each channel keeps the samples since the last flush, trimmed
   // to the window, and the mean is their zero-padded sum divided by the window.
   int unsigned hist [CHANNELS][$];
   int          m_k = MAX_LOG2;
   int          e_valid = 0, e_ch = 0, e_data = 0, e_full = 0;
   int unsigned m_sum, m_w;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) hist[c].delete();
         m_k = MAX_LOG2; e_valid = 0; e_ch = 0; e_data = 0; e_full = 0;
      end else if (clr) begin
         for (int c = 0; c < CHANNELS; c++) hist[c].delete();
         m_k = (int'(win_log2) > MAX_LOG2) ? MAX_LOG2 : int'(win_log2);
         e_valid = 0;
      end else if (in_valid && int'(in_ch) < CHANNELS) begin
         m_w = 1 << m_k;
         hist[in_ch].push_back(in_data);
         while (hist[in_ch].size() > m_w) void'(hist[in_ch].pop_front());
         m_sum = 0;
         foreach (hist[in_ch][i]) m_sum += hist[in_ch][i];
         if (m_k > 0) m_sum += 1 << (m_k - 1);
         e_data  = int'(m_sum >> m_k);
         if (e_data > 255) e_data = 255;
         e_full  = (hist[in_ch].size() == m_w) ? 1 : 0;
         e_ch    = int'(in_ch);
         e_valid = 1;
      end else begin
         e_valid = 0;
      end
   end

   always @(negedge clk) begin
      check("out_valid", out_valid, e_valid);
      check("k_active", k_active, m_k);
      check("out_ch", out_ch, e_ch);
      check("out_data", out_data, e_data);
      check("out_full", out_full, e_full);
   end

   task automatic send(input int ch, input int d);
      @(negedge clk);
      clr = 1'b0; in_valid = 1'b1; in_ch = CH_W'(ch); in_data = DATA_W'(d);
   endtask

   task automatic idle();
      @(negedge clk);
      clr = 1'b0; in_valid = 1'b0;
   endtask

   task automatic do_clr(input int k, input bit v, input int ch, input int d);
      @(negedge clk);
      clr = 1'b1; win_log2 = K_W'(k); in_valid = v; in_ch = CH_W'(ch); in_data = DATA_W'(d);
   endtask

   task automatic send_chk(input string name, input int ch, input int d, input int exp_d, input int exp_f);
      send(ch, d);
      @(posedge clk); #1;
      check({name, ".valid"}, out_valid, 1);
      check({name, ".data"}, out_data, exp_d);
      check({name, ".full"}, out_full, exp_f);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset.k_active", k_active, 4);
      check("reset.out_valid", out_valid, 0);
      check("reset.out_data", out_data, 0);

      // Async reset in the middle of a stream, then a fresh sum.
      for (int i = 0; i < 6; i++) send(0, 100 + i);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("async_rst.out_valid", out_valid, 0);
      check("async_rst.out_data", out_data, 0);
      check("async_rst.k_active", k_active, 4);
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      send_chk("fresh", 0, 160, 10, 0);

      // Window of 4 with rounding.
      do_clr(2, 1'b0, 0, 0);
      send_chk("k2_s1", 0, 4, 1, 0);
      send_chk("k2_s2", 0, 8, 3, 0);
      send_chk("k2_s3", 0, 12, 6, 0);
      send_chk("k2_s4", 0, 16, 10, 1);
      send_chk("k2_s5", 0, 20, 14, 1);

      // Out-of-range channel and idle cycles leave state untouched.
      send(3, 250);
      @(posedge clk); #1;
      check("bad_ch.out_valid", out_valid, 0);
      check("bad_ch.out_data", out_data, 14);
      idle();
      @(posedge clk); #1;
      check("idle.out_valid", out_valid, 0);
      send_chk("k2_after", 0, 24, 18, 1);

      // Interleaved channels, full window of 16.
      do_clr(4, 1'b0, 0, 0);
      for (int i = 1; i <= 16; i++) begin
         if (i == 15)      send_chk("ilv_ch0_15", 0, 255, 239, 0);
         else if (i == 16) send_chk("ilv_ch0_16", 0, 255, 255, 1);
         else              send(0, 255);
         if (i == 16)      send_chk("ilv_ch1_16", 1, 0, 0, 1);
         else              send(1, 0);
      end

      // Flush after a full window must not leak stale samples.
      do_clr(4, 1'b0, 0, 0);
      for (int i = 0; i < 16; i++) send(0, 200);
      do_clr(1, 1'b1, 0, 99);
      @(posedge clk); #1;
      check("clr_drop.out_valid", out_valid, 0);
      check("clr.k_active", k_active, 1);
      send_chk("k1_s1", 0, 10, 5, 0);
      send_chk("k1_s2", 0, 30, 20, 1);

      // Clamp and pass-through.
      do_clr(7, 1'b0, 0, 0);
      @(posedge clk); #1;
      check("clamp.k_active", k_active, 4);
      do_clr(0, 1'b0, 0, 0);
      send_chk("k0_s1", 1, 77, 77, 1);
      send_chk("k0_s2", 1, 200, 200, 1);
      send_chk("k0_s3", 2, 3, 3, 1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 199);
         if (r < 2)        do_clr($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                                  $urandom_range(0, 2), $urandom_range(0, 255));
         else if (r < 160) send($urandom_range(0, 3), $urandom_range(0, 255));
         else              idle();
      end
      idle();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
